// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
//
// Sample-clock generator for a UART receiver. Once the start-bit detector
// reports rx_start, the block runs one frame of FRAME_BITS bits. Each bit is
// split into OVERSAMPLE oversample periods of (active_div+1) clocks. The block
// emits an oversample tick, a mid-bit sample strobe, the current bit index and
// a frame-complete pulse for the downstream shift/deserialiser logic.
//
// Optional feature (compile-time macro UART_BAUD_AUTO_REARM_EN):
//   If the macro is defined and rx_start (without abort) is present on the
//   final oversample event of a frame, the block stays busy and starts the
//   next frame straight away, re-latching the divisor. Without the macro the
//   block always returns to IDLE at the end of a frame.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   cfg_div_en   1: use cfg_div as the divisor, 0: use DEF_DIV
//   cfg_div      runtime divisor; oversample period is cfg_div+1 clocks
//   rx_start     start bit detected; begins a frame when idle
//   abort        cancels the current frame (has priority over rx_start)
//   busy         frame in progress
//   os_tick      one-cycle pulse per oversample period
//   sample_tick  one-cycle pulse at the centre of each bit
//   bit_idx      index of the current bit, 0..FRAME_BITS-1
//   frame_done   one-cycle pulse when the last bit period ends
// ---------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLK_FREQUENCE = 50_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int OVERSAMPLE    = 16,
  parameter int FRAME_BITS    = 10,
  parameter int DIV_W         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_div_en,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic                          rx_start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          os_tick,
  output logic                          sample_tick,
  output logic [$clog2(FRAME_BITS)-1:0] bit_idx,
  output logic                          frame_done
);

  localparam int BIT_W     = $clog2(FRAME_BITS);
  localparam int OS_W      = $clog2(OVERSAMPLE);
  localparam int DEF_DIV_I = CLK_FREQUENCE / (BAUD_RATE * OVERSAMPLE) - 1;

  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEF_DIV_I);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  // Parameter legality is checked at elaboration time.
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_baud_gen: OVERSAMPLE must be even and >= 4");
  end
  if (FRAME_BITS < 2) begin : g_bad_frame_bits
    $error("uart_baud_gen: FRAME_BITS must be >= 2");
  end
  if (DEF_DIV_I < 0 || (DIV_W < 32 && (DEF_DIV_I >> DIV_W) != 0)) begin : g_bad_def_div
    $error("uart_baud_gen: default divisor does not fit in DIV_W bits");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] div_cnt;
  logic [OS_W-1:0]  os_cnt;

  logic             os_event;     // last clock of an oversample period
  logic             last_os;      // os_cnt is on the final period of a bit
  logic             final_event;  // last os event of the whole frame
  logic             rearm;        // final event with a back-to-back start
  logic             load;         // (re)start a frame this cycle
  logic [DIV_W-1:0] div_src;
  logic [DIV_W-1:0] div_load;

  // A divisor of 0 would give a one-clock period that the wrap compare cannot
  // distinguish from a stalled counter, so it is clamped to 1.
  assign div_src  = cfg_div_en ? cfg_div : DEF_DIV;
  assign div_load = (div_src == '0) ? DIV_ONE : div_src;

  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    rearm       = 1'b0;
    os_event    = (state == RUN) && (div_cnt == active_div);
    last_os     = (os_cnt == OS_LAST);
    final_event = os_event && last_os && (bit_idx == BIT_LAST);
`ifdef UART_BAUD_AUTO_REARM_EN
    rearm       = final_event && rx_start && !abort;
`endif

    case (state)
      IDLE: begin
        if (rx_start && !abort) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (final_event) begin
          if (rearm) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_div  <= '0;
      div_cnt     <= '0;
      os_cnt      <= '0;
      bit_idx     <= '0;
      os_tick     <= 1'b0;
      sample_tick <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      // Pulses trail their event by one clock; an abort seen on the event
      // cycle swallows them.
      os_tick     <= os_event && !abort;
      sample_tick <= os_event && !abort && (os_cnt == OS_MID);
      frame_done  <= final_event && !abort;

      if (load) begin
        active_div <= div_load;
        div_cnt    <= '0;
        os_cnt     <= '0;
        bit_idx    <= '0;
      end else if (state_nxt == IDLE) begin
        div_cnt <= '0;
        os_cnt  <= '0;
        bit_idx <= '0;
      end else if (os_event) begin
        div_cnt <= '0;
        if (last_os) begin
          os_cnt  <= '0;
          bit_idx <= bit_idx + BIT_ONE;
        end else begin
          os_cnt <= os_cnt + OS_ONE;
        end
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
    end
  end

  // state is itself a flop, so busy is a registered output.
  assign busy = (state == RUN);

endmodule

// File: tb/tb_uart_baud_gen.sv
// ---------------------------------------------------------------------------
// tb_uart_baud_gen
//
// Self-checking bench for uart_baud_gen with default parameters. A timing
// model predicts every output on every cycle from the frame start time and
// the latched divisor using plain arithmetic (tick k of a frame lands k
// oversample periods after the start). Directed scenarios cover the default
// divisor, a runtime divisor, the zero clamp, abort, reset and a held
// rx_start; a randomized phase follows. Outputs are sampled on the falling
// edge; inputs change on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_baud_gen;

  localparam int OS      = 16;
  localparam int FB      = 10;
  localparam int DIV_W   = 16;
  localparam int BW      = $clog2(FB);
  localparam int DEF_DIV = 324;  // 50 MHz / (9600 * 16) - 1

`ifdef UART_BAUD_AUTO_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_div_en;
  logic [DIV_W-1:0] cfg_div;
  logic             rx_start;
  logic             abort;
  logic             busy;
  logic             os_tick;
  logic             sample_tick;
  logic [BW-1:0]    bit_idx;
  logic             frame_done;

  int errors = 0;
  int checks = 0;

  uart_baud_gen #(
    .CLK_FREQUENCE (50_000_000),
    .BAUD_RATE     (9600),
    .OVERSAMPLE    (OS),
    .FRAME_BITS    (FB),
    .DIV_W         (DIV_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_div_en  (cfg_div_en),
    .cfg_div     (cfg_div),
    .rx_start    (rx_start),
    .abort       (abort),
    .busy        (busy),
    .os_tick     (os_tick),
    .sample_tick (sample_tick),
    .bit_idx     (bit_idx),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- timing model ----------------
  int now      = 0;     // number of rising edges so far
  bit m_active = 1'b0;  // a frame is running after edge `now`
  int m_start  = 0;     // edge at which the running frame was accepted
  int m_d      = 0;     // latched divisor of the running frame
  bit m_end    = 1'b0;  // a frame completed at edge `now`

  // observation trackers; times are spec-style offsets (edge - start + 1)
  int t_acc     = 0;
  int first_os  = -1;
  int first_smp = -1;
  int done_at   = -1;
  int n_smp     = 0;
  int n_os      = 0;
  int last_done = -1;
  int prev_done = -1;
  bit done_busy = 1'b0;

  function automatic int pick_div(input bit en, input int div);
    int d;
    d = en ? div : DEF_DIV;
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int frame_len(input int d);
    return OS * FB * (d + 1);
  endfunction

  function automatic logic [BW+3:0] exp_outputs();
    logic b, o, s, f;
    int   j, per, bi;
    b = 1'b0; o = 1'b0; s = 1'b0; f = 1'b0; bi = 0;
    j = 0; per = 1;
    if (m_active) begin
      j   = now - m_start;
      per = m_d + 1;
      b   = 1'b1;
      if (j > 0 && (j % per) == 0) begin
        o = 1'b1;
        s = (((j / per) % OS) == OS / 2);
      end
      bi = j / (OS * per);
    end
    if (m_end) begin
      o = 1'b1;
      f = 1'b1;
    end
    return {b, o, s, f, BW'(bi)};
  endfunction

  task automatic restart_track(input int t);
    t_acc     = t;
    first_os  = -1;
    first_smp = -1;
    done_at   = -1;
    n_smp     = 0;
    n_os      = 0;
  endtask

  // Apply one cycle of inputs, advance the model across the next rising edge,
  // then compare every output at the following falling edge.
  task automatic step(input bit r, input bit rx, input bit ab, input bit en, input int div);
    int nx;
    rst        = r;
    rx_start   = rx;
    abort      = ab;
    cfg_div_en = en;
    cfg_div    = DIV_W'(div);
    nx    = now + 1;
    m_end = 1'b0;
    if (r) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (ab) begin
        m_active = 1'b0;
      end else if (nx - m_start == frame_len(m_d)) begin
        m_end = 1'b1;
        if (REARM && rx) begin
          m_start = nx;
          m_d     = pick_div(en, div);
          restart_track(nx);
        end else begin
          m_active = 1'b0;
        end
      end
    end else if (rx && !ab) begin
      m_active = 1'b1;
      m_start  = nx;
      m_d      = pick_div(en, div);
      restart_track(nx);
    end

    @(negedge clk);
    now = nx;
    check("outputs", {busy, os_tick, sample_tick, frame_done, bit_idx}, exp_outputs());
    if (os_tick === 1'b1) begin
      n_os++;
      if (first_os < 0) first_os = now - t_acc + 1;
    end
    if (sample_tick === 1'b1) begin
      check("sample_bit_idx", bit_idx, n_smp);
      n_smp++;
      if (first_smp < 0) first_smp = now - t_acc + 1;
    end
    if (frame_done === 1'b1) begin
      done_at   = now - t_acc + 1;
      prev_done = last_done;
      last_done = now;
      done_busy = busy;
    end
  endtask

  initial begin
    bit r_v, rx_v, ab_v, en_v;
    int div_v;

    // reset, then abort while idle
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("reset_outputs", {busy, os_tick, sample_tick, frame_done, bit_idx}, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    check("abort_idle_busy", busy, 1'b0);

    // default divisor frame
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    repeat (52005) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("def_first_os", first_os, 326);
    check("def_first_smp", first_smp, 2601);
    check("def_frame_done", done_at, 52001);
    check("def_n_smp", n_smp, 10);

    // runtime divisor 3
    step(1'b0, 1'b1, 1'b0, 1'b1, 3);
    repeat (700) step(1'b0, 1'b0, 1'b0, 1'b1, 3);
    check("div3_first_os", first_os, 5);
    check("div3_first_smp", first_smp, 33);
    check("div3_frame_done", done_at, 641);
    check("div3_n_smp", n_smp, 10);
    check("div3_n_os", n_os, 160);

    // divisor 0 clamps to 1; cfg_div change mid-frame is ignored
    step(1'b0, 1'b1, 1'b0, 1'b1, 0);
    repeat (50) step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    repeat (400) step(1'b0, 1'b0, 1'b0, 1'b1, 7);
    check("clamp_first_os", first_os, 3);
    check("clamp_frame_done", done_at, 321);
    check("clamp_n_os", n_os, 160);

    // abort at T+100 of a divisor-3 frame
    step(1'b0, 1'b1, 1'b0, 1'b1, 3);
    repeat (99) step(1'b0, 1'b0, 1'b0, 1'b1, 3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3);
    check("abort_busy", busy, 1'b0);
    n_os    = 0;
    done_at = -1;
    repeat (700) step(1'b0, 1'b0, 1'b0, 1'b1, 3);
    check("abort_no_ticks", n_os, 0);
    check("abort_no_done", done_at, -1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 3);
    check("start_abort_idle", busy, 1'b0);

    // reset mid-frame
    step(1'b0, 1'b1, 1'b0, 1'b1, 3);
    repeat (50) step(1'b0, 1'b0, 1'b0, 1'b1, 3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3);
    check("rst_mid_outputs", {busy, os_tick, sample_tick, frame_done, bit_idx}, '0);

    // rx_start held high across frame boundaries
    last_done = -1;
    prev_done = -1;
    repeat (1500) step(1'b0, 1'b1, 1'b0, 1'b1, 3);
    check("held_done_interval", last_done - prev_done, REARM ? 640 : 641);
    check("held_busy_at_done", done_busy, REARM);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3);

    // randomized traffic
    repeat (3000) begin
      r_v   = ($urandom_range(0, 999) == 0);
      rx_v  = ($urandom_range(0, 39) == 0);
      ab_v  = ($urandom_range(0, 299) == 0);
      en_v  = ($urandom_range(0, 7) != 0);
      div_v = $urandom_range(0, 4);
      step(r_v, rx_v, ab_v, en_v, div_v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Parametrised successor to the UART receive sample-clock generator. Generates an oversample tick, a mid-bit sample strobe and a bit index for one UART frame, then signals frame completion. Supports configurable oversample ratio and frame length, and a runtime-programmable divisor. Sits between the RX line start-bit detector and the RX shift/deserialiser logic.

Parameters:
CLK_FREQUENCE, 50_000_000, system clock frequency in Hz.
BAUD_RATE, 9600, default baud rate.
OVERSAMPLE, 16, oversample ticks per bit. Must be even and >= 4; any other value is an elaboration error.
FRAME_BITS, 10, bits per frame (start + data + parity + stop). Must be >= 2.
DIV_W, 16, width of the runtime divisor.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
cfg_div_en  input  1  1: use cfg_div; 0: use DEF_DIV
cfg_div  input  DIV_W  runtime divisor. Oversample period is cfg_div+1 clocks.
rx_start  input  1  start-bit detected; begins a frame
abort  input  1  cancels the current frame
busy  output  1  frame in progress
os_tick  output  1  one-cycle pulse per oversample period
sample_tick  output  1  one-cycle pulse at the centre of each bit
bit_idx  output  $clog2(FRAME_BITS)  index of the current bit, 0..FRAME_BITS-1
frame_done  output  1  one-cycle pulse when the last bit period ends

Behaviour:
- Reset and outputs:
  - DEF_DIV = CLK_FREQUENCE/(BAUD_RATE*OVERSAMPLE) - 1, using integer division (324 for the defaults).
  - Reset is sampled on the clk posedge. It forces state IDLE and clears all counters. All outputs reset to 0.
  - All outputs are registered.
- States:
  - IDLE -> RUN when rx_start=1 and abort=0.
  - RUN -> IDLE on abort=1, or on the final oversample event of the frame.
- Divisor latch:
  - At the cycle rx_start is accepted, active_div is latched as (cfg_div_en ? cfg_div : DEF_DIV).
  - A latched value of 0 is clamped to 1.
  - cfg_div changes during RUN have no effect until the next frame.
- Counters in RUN:
  - div_cnt counts 0..active_div, then wraps to 0.
  - The cycle in which div_cnt==active_div is an "os event".
  - os_cnt counts os events 0..OVERSAMPLE-1, then wraps.
  - bit_idx increments on the os event where os_cnt==OVERSAMPLE-1.
- Output pulses (each asserted the cycle after its triggering event):
  - os_tick: after every os event.
  - sample_tick: after the os event where os_cnt==OVERSAMPLE/2-1, i.e. the centre of the bit.
  - frame_done: after the os event where os_cnt==OVERSAMPLE-1 and bit_idx==FRAME_BITS-1. On that event state goes to IDLE, so busy falls in the same cycle frame_done is high, and bit_idx reads 0.
- Latency, with rx_start accepted at edge T:
  - busy=1 from T+1; div_cnt=0 at T+1.
  - The k-th os_tick is high at T+k*(active_div+1)+1.
  - The first sample_tick is high at T+(OVERSAMPLE/2)*(active_div+1)+1.
  - frame_done is high at T+OVERSAMPLE*FRAME_BITS*(active_div+1)+1.
- Boundary cases:
  - rx_start during RUN is ignored.
  - abort has priority over rx_start in the same cycle.
  - abort during RUN: IDLE next cycle, counters cleared, and no frame_done, os_tick or sample_tick is generated from that cycle on.
  - abort in IDLE has no effect.
  - Reset mid-frame behaves as abort, plus outputs are cleared immediately.
  - Counter widths are sized so no counter overflows for any legal parameter set.

Optional Feature:
Macro UART_BAUD_AUTO_REARM_EN.
- Defined: if rx_start=1 (and abort=0) in the cycle of the final os event, the block stays in RUN and restarts with bit_idx=0, div_cnt=0, os_cnt=0.
  - active_div is re-latched at that point.
  - frame_done still pulses, and busy stays 1 with no gap.
- Undefined: rx_start in that cycle is ignored, the block returns to IDLE, and a new frame needs rx_start while in IDLE.

Test Plan:
1. Defaults with cfg_div_en=0, rx_start pulse at T -> first os_tick at T+326, first sample_tick at T+2601, frame_done and busy fall at T+52001; exactly 10 sample_ticks with bit_idx 0..9.
2. cfg_div_en=1, cfg_div=3, OVERSAMPLE=16, FRAME_BITS=10 -> os_tick every 4 cycles, sample_ticks at T+33+64n, frame_done at T+641.
3. cfg_div=0 -> clamped to 1: os_tick every 2 cycles. Changing cfg_div to 7 mid-frame -> period unchanged until the next rx_start.
4. abort at T+100 during the cfg_div=3 frame -> busy=0 at T+101, no further ticks, no frame_done; rx_start+abort in the same cycle in IDLE -> stays IDLE.
5. rst asserted mid-frame -> all outputs 0 on the next cycle. rx_start held high continuously -> one frame, then the next frame starts one cycle after busy falls (auto-rearm undefined).
6. UART_BAUD_AUTO_REARM_EN defined, rx_start high on the final os event -> frame_done=1, busy stays 1, bit_idx=0, next frame_done exactly 640 cycles later (cfg_div=3).
